// File: rtl/eng_pkg.sv
// eng_pkg: shared geometry and parity word/row types for the engine output path.
package eng_pkg;
    localparam int W = 4;
    localparam int PACKET_LENGTH = 2;
    localparam int PCK_TREE_XOR_UNITS_NUM = 2;
    typedef logic [W-1:0][PACKET_LENGTH-1:0] parity_row_t;
    typedef parity_row_t [PCK_TREE_XOR_UNITS_NUM-1:0] parity_word_t;
endpackage

// File: rtl/outbuf_mem.sv
// outbuf_mem: parity word storage, one synchronous write port, one asynchronous read port.
module outbuf_mem
    import eng_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  parity_word_t wdata,
    input  logic [AW-1:0] raddr,
    output parity_word_t rdata
);
    parity_word_t mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/eng_outbuf.sv
// eng_outbuf: FIFO of engine parity words, acked per write, streamed to the host one row per beat.
module eng_outbuf
    import eng_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int ROW_W = (PCK_TREE_XOR_UNITS_NUM > 1) ? $clog2(PCK_TREE_XOR_UNITS_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PACKET_LENGTH-1:0] eng_outbuf_dout_reg [0:PCK_TREE_XOR_UNITS_NUM-1][0:W-1],
    input  logic                     eng_outbuf_wr_req,
    output logic                     outbuf_eng_wr_ack,
    output logic                     outbuf_eng_full,
    input  logic                     outbuf_flush,
    output logic [W*PACKET_LENGTH-1:0] outbuf_dout,
    output logic [ROW_W-1:0]         outbuf_dout_row,
    output logic                     outbuf_dout_val,
    input  logic                     host_outbuf_rdy,
    output logic                     outbuf_empty,
    output logic [CNT_W-1:0]         outbuf_cnt,
    output logic                     outbuf_ovf_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(PCK_TREE_XOR_UNITS_NUM - 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             ack_q, ack_d, ovf_q, ovf_d;
    logic             push, beat, pop;
    parity_word_t     wr_word, rd_word;

    always_comb begin
        wr_word = '0;
        for (int r = 0; r < PCK_TREE_XOR_UNITS_NUM; r++)
            for (int p = 0; p < W; p++)
                wr_word[r][p] = eng_outbuf_dout_reg[r][p];
    end

    assign outbuf_eng_full = cnt_q == CNT_W'(DEPTH);
    assign outbuf_empty    = cnt_q == '0;
    assign outbuf_dout_val = !outbuf_empty;

    // ack_q blocks a second write of the request the engine is still holding
    always_comb begin
        push     = eng_outbuf_wr_req && !outbuf_eng_full && !outbuf_flush && !ack_q;
        beat     = outbuf_dout_val && host_outbuf_rdy && !outbuf_flush;
        pop      = beat && row_q == ROW_LAST;
        wr_ptr_d = outbuf_flush ? '0 : wr_ptr_q + PTR_W'(push);
        rd_ptr_d = outbuf_flush ? '0 : rd_ptr_q + PTR_W'(pop);
        cnt_d    = outbuf_flush ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
        row_d    = (outbuf_flush || pop) ? '0 : row_q + ROW_W'(beat);
        ack_d    = push;
        ovf_d    = ovf_q || (eng_outbuf_wr_req && outbuf_eng_full && !ack_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            row_q    <= '0;
            ack_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            ack_q    <= ack_d;
            ovf_q    <= ovf_d;
        end
    end

    outbuf_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_word),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    assign outbuf_dout       = rd_word[row_q];
    assign outbuf_dout_row   = row_q;
    assign outbuf_eng_wr_ack = ack_q;
    assign outbuf_cnt        = cnt_q;
    assign outbuf_ovf_err    = ovf_q;
endmodule

// File: tb/tb_eng_outbuf.sv
// tb_eng_outbuf: table vectors plus a per-cycle scoreboard model of eng_outbuf.
module tb_eng_outbuf;
    logic       clk = 0, rst = 1, req = 0, flush = 0, rdy = 0;
    logic [1:0] din [0:1][0:3];
    logic       ack, full, val, empty, ovf, row;
    logic [7:0] dout;
    logic [3:0] cnt;

    eng_outbuf dut (
        .clk(clk), .rst(rst), .eng_outbuf_dout_reg(din), .eng_outbuf_wr_req(req),
        .outbuf_eng_wr_ack(ack), .outbuf_eng_full(full), .outbuf_flush(flush),
        .outbuf_dout(dout), .outbuf_dout_row(row), .outbuf_dout_val(val),
        .host_outbuf_rdy(rdy), .outbuf_empty(empty), .outbuf_cnt(cnt), .outbuf_ovf_err(ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    logic [15:0] cur_w, head;
    logic [15:0] exp_q [$];
    int m_cnt = 0, m_row = 0, dut_beats = 0, dut_max = 0;
    logic m_ack = 0, m_ovf = 0, m_full, m_push, m_beat, m_pop;

    typedef struct { logic req, rdy, ack, val, empty, row; logic [7:0] dout; } vec_t;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_word(input logic [15:0] w);
        cur_w = w;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 4; p++)
                din[r][p] = w[r*8 + p*2 +: 2];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        int i;
        set_word(w);
        req = 1;
        for (i = 0; i < 64; i++) begin
            step();
            if (ack) break;
        end
        req = 0;
        n_vec++;
        if (i == 64) begin
            n_err++;
            $display("FAIL write_ack_timeout: got no ack expected ack within 64 cycles");
        end
    endtask

    task automatic drain();
        rdy = 1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
        step();
        rdy = 0;
        chk("drain_empty", empty, 1);
    endtask

    // scoreboard: check current outputs, then advance the model for the coming edge
    always @(negedge clk) begin
        if (rst) begin
            m_cnt = 0; m_row = 0; m_ack = 0; m_ovf = 0;
            exp_q.delete();
        end else begin
            chk("ack", ack, m_ack);
            chk("full", full, m_cnt == 8);
            chk("empty", empty, m_cnt == 0);
            chk("val", val, m_cnt != 0);
            chk("cnt", cnt, m_cnt);
            chk("ovf", ovf, m_ovf);
            if (m_cnt != 0 && exp_q.size() != 0) begin
                head = exp_q[0];
                chk("dout", dout, head[m_row*8 +: 8]);
                chk("row", row, m_row);
            end
            if (val && rdy && !flush) dut_beats++;
            if (int'(cnt) > dut_max) dut_max = cnt;
            m_full = m_cnt == 8;
            m_push = req && !m_full && !flush && !m_ack;
            m_beat = m_cnt != 0 && rdy && !flush;
            m_pop  = m_beat && m_row == 1;
            if (req && m_full && !m_ack) m_ovf = 1;
            m_ack = m_push;
            if (flush) begin
                m_cnt = 0; m_row = 0;
                exp_q.delete();
            end else begin
                if (m_pop) void'(exp_q.pop_front());
                if (m_push) exp_q.push_back(cur_w);
                m_cnt = m_cnt + int'(m_push) - int'(m_pop);
                m_row = m_pop ? 0 : m_row + int'(m_beat);
            end
        end
    end

    initial begin
        int b0;
        tbl[0] = '{req:1, rdy:1, ack:0, val:0, empty:1, row:0, dout:8'h00};
        tbl[1] = '{req:1, rdy:1, ack:1, val:1, empty:0, row:0, dout:8'h2D};
        tbl[2] = '{req:0, rdy:1, ack:0, val:1, empty:0, row:1, dout:8'hB4};
        tbl[3] = '{req:0, rdy:1, ack:0, val:0, empty:1, row:0, dout:8'h00};
        set_word(16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        set_word(16'hB42D);
        for (int i = 0; i < 4; i++) begin
            req = tbl[i].req;
            rdy = tbl[i].rdy;
            @(negedge clk);
            chk("tbl_ack", ack, tbl[i].ack);
            chk("tbl_val", val, tbl[i].val);
            chk("tbl_empty", empty, tbl[i].empty);
            if (tbl[i].val) begin
                chk("tbl_dout", dout, tbl[i].dout);
                chk("tbl_row", row, tbl[i].row);
            end
            step();
        end
        req = 0; rdy = 0;

        for (int i = 0; i < 8; i++) write_word(16'(i * 16'h1357 + 16'h0A0B));
        chk("fill_full", full, 1);
        chk("fill_cnt", cnt, 8);
        set_word(16'hC3E1);
        req = 1;
        repeat (3) step();
        chk("ovf_set", ovf, 1);
        chk("ovf_noack", ack, 0);
        fork
            write_word(16'hC3E1);
            drain();
        join
        chk("fill_rows", dut_beats, 2 + 18);

        for (int i = 0; i < 3; i++) write_word(16'($urandom));
        b0 = dut_beats;
        for (int i = 0; i < 40 && dut_beats - b0 < 6; i++) begin
            rdy = ~rdy;
            step();
        end
        repeat (4) begin rdy = ~rdy; step(); end
        rdy = 0;
        chk("bp_beats", dut_beats - b0, 6);
        chk("bp_empty", empty, 1);

        dut_max = 0;
        rdy = 1;
        for (int i = 0; i < 20; i++) write_word(16'($urandom));
        drain();
        chk("wrap_max_cnt", dut_max <= 8, 1);

        for (int i = 0; i < 3; i++) write_word(16'($urandom));
        chk("pre_flush_cnt", cnt, 3);
        set_word(16'h5A5A);
        req = 1; rdy = 1; flush = 1;
        step();
        flush = 0; req = 0; rdy = 0;
        chk("flush_cnt", cnt, 0);
        chk("flush_empty", empty, 1);
        chk("flush_val", val, 0);
        chk("flush_ack", ack, 0);
        chk("flush_ovf", ovf, 1);
        step();

        write_word(16'h9876);
        rdy = 1;
        step();
        rdy = 0;
        chk("mid_row", row, 1);
        set_word(16'h7E81);
        req = 1;
        #2 rst = 1;
        #1;
        chk("arst_val", val, 0);
        chk("arst_empty", empty, 1);
        chk("arst_cnt", cnt, 0);
        chk("arst_row", row, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_full", full, 0);
        chk("arst_ack", ack, 0);
        step();
        rst = 0;
        step();
        chk("post_rst_ack", ack, 1);
        chk("post_rst_row", row, 0);
        chk("post_rst_dout", dout, 8'h81);
        req = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
